// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one 16-bit adder (sum + flags) among NUM_REQ requesters
// through round-robin arbitration. The response is registered and tagged with
// the ID of the requester it belongs to.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | arbitrate; grant one requester and latch its operands
// ST_EXEC | latched operands drive the shared adder; result registered
// ST_RESP | response presented; held until rsp_ready
module adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [16*NUM_REQ-1:0]   req_a,
   input  logic [16*NUM_REQ-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [15:0]             rsp_sum,
   output logic [4:0]              rsp_flags,
   output logic                    busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [15:0]       op_a_q, op_a_d;
   logic [15:0]       op_b_q, op_b_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [15:0]       rsp_sum_q, rsp_sum_d;
   logic [4:0]        rsp_flags_q, rsp_flags_d;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic [ID_W:0]     cand;
   logic [NUM_REQ-1:0] grant_vec;

   logic [16:0]       add_full;
   logic [15:0]       add_sum;
   logic [4:0]        add_flags;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[ID_W-1:0];
         end
      end
   end

   // Shared adder: carry-in is always 0; flags packed {ovf, parity, carry, zero, sign}.
   always_comb begin
      add_full  = {1'b0, op_a_q} + {1'b0, op_b_q};
      add_sum   = add_full[15:0];
      add_flags = {
         (op_a_q[15] == op_b_q[15]) && (add_sum[15] != op_a_q[15]),
         ~^add_sum,
         add_full[16],
         (add_sum == 16'h0000),
         add_sum[15]
      };
   end

   // Next-state and grant decode.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_flags_d = rsp_flags_q;
      grant_vec   = '0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_found) begin
               grant_vec[gnt_idx] = 1'b1;
               op_a_d   = req_a[16*gnt_idx +: 16];
               op_b_d   = req_b[16*gnt_idx +: 16];
               id_d     = gnt_idx;
               rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_sum_d   = add_sum;
            rsp_flags_d = add_flags;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end

   // Grant is suppressed while reset is asserted.
   assign req_ready = rst_n ? grant_vec : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_flags = rsp_flags_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
